// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer: entry layout and FSM states.
package wb_trace_buffer_pkg;

    localparam int TRACE_W  = 69;
    localparam int DATA_LSB = 0;
    localparam int RD_LSB   = 32;
    localparam int PC_LSB   = 37;

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_FROZEN  = 1'b1
    } state_t;

    function automatic logic [TRACE_W-1:0] pack_entry(input logic [31:0] pc,
                                                      input logic [4:0]  rd,
                                                      input logic [31:0] data);
        return {pc, rd, data};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: registered storage, combinational head read,
// separate occupancy counter, synchronous clear with priority over push/pop.
module sync_fifo #(
    parameter int WIDTH  = 69,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == (ADDR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign rdata   = mem[rd_ptr_reg];
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Taps register-file write-backs (pc, rd, value) and streams them out over valid/ready,
// with freeze control, sticky overflow and a saturating drop counter.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [31:0]       wb_pc,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              freeze,
    input  logic              clear,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [4:0]        trace_rd,
    output logic [31:0]       trace_data,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    state_t             state_reg;
    state_t             state_next;
    logic               capture;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic [TRACE_W-1:0] head;
    logic [TRACE_W-1:0] head_masked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_CAPTURE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CAPTURE: if (freeze)  state_next = ST_FROZEN;
            ST_FROZEN:  if (!freeze) state_next = ST_CAPTURE;
            default:                 state_next = ST_CAPTURE;
        endcase
    end

    // freeze gates capture in the very cycle it rises, not only once FROZEN is reached.
    assign capture = wb_en & (wb_rd != 5'd0) & (state_reg == ST_CAPTURE) & ~freeze;
    assign pop     = trace_valid & trace_ready;
    assign drop    = capture & full & ~pop;

    sync_fifo #(
        .WIDTH  (TRACE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .push   (capture),
        .pop    (pop),
        .wdata  (pack_entry(wb_pc, wb_rd, wb_data)),
        .rdata  (head),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    // Storage is not reset, so fields read as zero whenever nothing is held.
    assign trace_valid = ~empty;
    assign head_masked = empty ? '0 : head;
    assign trace_pc    = head_masked[PC_LSB +: 32];
    assign trace_rd    = head_masked[RD_LSB +: 5];
    assign trace_data  = head_masked[DATA_LSB +: 32];

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer: one task per scenario.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        freeze;
    logic        clear;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_trace_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (wb_en),
        .wb_pc       (wb_pc),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .freeze      (freeze),
        .clear       (clear),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_rd    (trace_rd),
        .trace_data  (trace_data),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_en = 1'b0; wb_pc = '0; wb_rd = '0; wb_data = '0;
        freeze = 1'b0; clear = 1'b0; trace_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (level !== 5'd0 || trace_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0 ||
            trace_pc !== 32'd0 || trace_rd !== 5'd0 || trace_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: level=%0d valid=%b ovf=%b drops=%0d pc=%h rd=%0d data=%h, required all zero",
                     level, trace_valid, overflow, drop_count, trace_pc, trace_rd, trace_data);
        end
        $display("reset: level=%0d valid=%b", level, trace_valid);
    endtask

    task automatic test_basic_flow();
        wb_en = 1'b1; wb_pc = 32'h0040_0000; wb_rd = 5'd8; wb_data = 32'h5;
        tick();
        wb_en = 1'b0; wb_pc = 32'hDEAD_BEEF; wb_rd = 5'd3; wb_data = 32'h77;
        checks++;
        if (trace_valid !== 1'b1 || trace_pc !== 32'h0040_0000 || trace_rd !== 5'd8 || trace_data !== 32'h5) begin
            errors++;
            $display("FAIL basic_first: valid=%b pc=%h rd=%0d data=%h, required 1 00400000 8 00000005",
                     trace_valid, trace_pc, trace_rd, trace_data);
        end
        tick(); tick();
        checks++;
        if (trace_valid !== 1'b1 || trace_pc !== 32'h0040_0000 || trace_rd !== 5'd8 || trace_data !== 32'h5) begin
            errors++;
            $display("FAIL basic_hold: valid=%b pc=%h rd=%0d data=%h, required 1 00400000 8 00000005",
                     trace_valid, trace_pc, trace_rd, trace_data);
        end
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        checks++;
        if (level !== 5'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: level=%0d valid=%b, required 0 0", level, trace_valid);
        end
        $display("basic_flow: pc=00400000 rd=8 data=5 drained, level=%0d", level);
    endtask

    task automatic test_zero_filter();
        wb_en = 1'b1; wb_pc = 32'h100; wb_rd = 5'd0; wb_data = 32'hFEFE;
        tick();
        wb_en = 1'b0;
        checks++;
        if (level !== 5'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_filter: level=%0d valid=%b, required 0 0", level, trace_valid);
        end
        $display("zero_filter: rd=0 write, level=%0d", level);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) begin
            wb_en = 1'b1; wb_pc = 32'h1000 + 32'(i) * 4; wb_rd = 5'd1 + 5'(i % 31); wb_data = 32'(i);
            tick();
        end
        wb_en = 1'b0;
        checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd2) begin
            errors++;
            $display("FAIL overflow: level=%0d ovf=%b drops=%0d, required 16 1 2", level, overflow, drop_count);
        end
        $display("overflow: level=%0d ovf=%b drops=%0d", level, overflow, drop_count);
    endtask

    task automatic test_full_push_pop();
        // Head (data 0) leaves while data 0xAA enters at the tail.
        wb_en = 1'b1; wb_pc = 32'h2000; wb_rd = 5'd9; wb_data = 32'hAA; trace_ready = 1'b1;
        tick();
        wb_en = 1'b0; trace_ready = 1'b0;
        checks++;
        if (level !== 5'd16 || drop_count !== 8'd2 || trace_data !== 32'd1) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d drops=%0d head=%h, required 16 2 00000001",
                     level, drop_count, trace_data);
        end
        $display("full_push_pop: level=%0d drops=%0d", level, drop_count);
        trace_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] exp_data;
            exp_data = (i == 16) ? 32'hAA : 32'(i);
            checks++;
            if (trace_valid !== 1'b1 || trace_data !== exp_data) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b data=%h, required 1 %h", i, trace_valid, trace_data, exp_data);
            end
            $display("drain %0d: data=%h", i, trace_data);
            tick();
        end
        trace_ready = 1'b0;
        checks++;
        if (level !== 5'd0 || trace_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: level=%0d valid=%b ovf=%b, required 0 0 1", level, trace_valid, overflow);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h300 + 32'(i);
            tick();
        end
        wb_en = 1'b0;
        checks++;
        if (level !== 5'd5 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre: level=%0d ovf=%b, required 5 1", level, overflow);
        end
        clear = 1'b1; wb_en = 1'b1; wb_rd = 5'd6;
        tick();
        clear = 1'b0; wb_en = 1'b0;
        checks++;
        if (level !== 5'd0 || overflow !== 1'b0 || drop_count !== 8'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear: level=%0d ovf=%b drops=%0d valid=%b, required 0 0 0 0",
                     level, overflow, drop_count, trace_valid);
        end
        $display("clear: level=%0d ovf=%b drops=%0d", level, overflow, drop_count);
    endtask

    task automatic test_freeze();
        freeze = 1'b1; wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        tick(); tick(); tick();
        checks++;
        if (level !== 5'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL freeze_hold: level=%0d drops=%0d, required 0 0", level, drop_count);
        end
        freeze = 1'b0; wb_data = 32'h56;
        tick();
        checks++;
        if (level !== 5'd0) begin
            errors++;
            $display("FAIL freeze_release: level=%0d, required 0", level);
        end
        wb_data = 32'h57;
        tick();
        wb_en = 1'b0;
        checks++;
        if (level !== 5'd1 || trace_data !== 32'h57) begin
            errors++;
            $display("FAIL freeze_resume: level=%0d data=%h, required 1 00000057", level, trace_data);
        end
        $display("freeze: resumed, level=%0d data=%h", level, trace_data);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h900 + 32'(i);
            tick();
        end
        wb_en = 1'b0;
        checks++;
        if (level !== 5'd3) begin
            errors++;
            $display("FAIL reset_pre: level=%0d, required 3", level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (trace_valid !== 1'b0 || level !== 5'd0 || trace_data !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b level=%0d data=%h, required 0 0 0", trace_valid, level, trace_data);
        end
        $display("async_reset: valid=%b level=%0d", trace_valid, level);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_flow();
        test_zero_filter();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
